master_axi_write_response_tracker: RTL and testbench

Tracks up to DEPTH outstanding AXI write transactions and collects their write responses (BRESP, BID) into an internal FIFO, which the system side drains through a valid/ready handshake. Sits between the write address/data issue logic and system-side status logic. Generalises the single-shot write response channel to multiple outstanding transactions with ID capture, credit-based flow control and optional error counting.

---
 rtl/master_axi_write_response_tracker.sv | 124 ++++++++++++
 tb/tb_master_axi_write_response_tracker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/master_axi_write_response_tracker.sv
// Tracks up to DEPTH outstanding AXI write transactions and buffers their B responses in a FIFO.
// Define MASTER_AXI_WRITE_RESPONSE_ERROR_COUNT_EN to build the saturating error-response counter.
module master_axi_write_response_tracker #(
    parameter int unsigned BRESP_WIDTH = 2,
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned COUNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       control_issue,
    output logic                       issue_ready,
    output logic [$clog2(DEPTH+1)-1:0] outstanding,
    output logic                       control_busy,
    input  logic [BRESP_WIDTH-1:0]     bresp,
    input  logic [ID_WIDTH-1:0]        bid,
    input  logic                       bvalid,
    output logic                       bready,
    output logic [BRESP_WIDTH-1:0]     system_response,
    output logic [ID_WIDTH-1:0]        system_id,
    output logic                       system_error,
    output logic                       system_valid,
    input  logic                       system_ready,
    input  logic                       error_clear,
    output logic [COUNT_WIDTH-1:0]     error_count
);

    localparam int unsigned OUT_W   = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam int unsigned PTR_W   = IDX_W + 1;
    localparam int unsigned SUM_W   = ((OUT_W > PTR_W) ? OUT_W : PTR_W) + 1;
    localparam int unsigned ENTRY_W = BRESP_WIDTH + ID_WIDTH;

    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W-1:0]   occupancy;
    logic [SUM_W-1:0]   credit_used;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               fifo_empty;
    logic               issue_ok;
    logic               accept;
    logic               pop;

    // Pointers carry one extra MSB so full and empty differ; subtraction wraps naturally.
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign occupancy   = wr_ptr_q - rd_ptr_q;
    assign credit_used = SUM_W'(outstanding_q) + SUM_W'(occupancy);

    // Flow-control outputs come from registered state only.
    assign issue_ready  = (credit_used < SUM_W'(DEPTH));
    assign bready       = (outstanding_q != '0);
    assign system_valid = !fifo_empty;
    assign control_busy = (outstanding_q != '0) || !fifo_empty;
    assign outstanding  = outstanding_q;

    assign issue_ok = control_issue && issue_ready;
    assign accept   = bvalid && bready;
    assign pop      = system_valid && system_ready;

    always_comb begin
        outstanding_d = outstanding_q;
        if (issue_ok && !accept) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!issue_ok && accept) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    // No full check on push: the credit rule leaves a free slot whenever a response is owed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q[IDX_W-1:0]] <= {bid, bresp};
                wr_ptr_q                   <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    assign head            = mem_q[rd_ptr_q[IDX_W-1:0]];
    assign system_response = head[BRESP_WIDTH-1:0];
    assign system_id       = head[ENTRY_W-1:BRESP_WIDTH];
    assign system_error    = system_response[1];

`ifdef MASTER_AXI_WRITE_RESPONSE_ERROR_COUNT_EN
    logic [COUNT_WIDTH-1:0] error_count_q;

    // Clear wins; an error accepted in the clearing cycle is deliberately dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            error_count_q <= '0;
        end else if (error_clear) begin
            error_count_q <= '0;
        end else if (accept && bresp[1] && (error_count_q != '1)) begin
            error_count_q <= error_count_q + COUNT_WIDTH'(1);
        end
    end

    assign error_count = error_count_q;
`else
    logic unused_error_clear;

    assign unused_error_clear = error_clear;
    assign error_count        = '0;
`endif

endmodule

// File: tb/tb_master_axi_write_response_tracker.sv
// Randomized and directed bench for master_axi_write_response_tracker against a queue-based model.
module tb_master_axi_write_response_tracker;

    localparam int BW    = 2;
    localparam int IW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          control_issue;
    logic          issue_ready;
    logic [2:0]    outstanding;
    logic          control_busy;
    logic [BW-1:0] bresp;
    logic [IW-1:0] bid;
    logic          bvalid;
    logic          bready;
    logic [BW-1:0] system_response;
    logic [IW-1:0] system_id;
    logic          system_error;
    logic          system_valid;
    logic          system_ready;
    logic          error_clear;
    logic [CW-1:0] error_count;

    master_axi_write_response_tracker #(
        .BRESP_WIDTH(BW),
        .ID_WIDTH   (IW),
        .DEPTH      (DEPTH),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .control_issue  (control_issue),
        .issue_ready    (issue_ready),
        .outstanding    (outstanding),
        .control_busy   (control_busy),
        .bresp          (bresp),
        .bid            (bid),
        .bvalid         (bvalid),
        .bready         (bready),
        .system_response(system_response),
        .system_id      (system_id),
        .system_error   (system_error),
        .system_valid   (system_valid),
        .system_ready   (system_ready),
        .error_clear    (error_clear),
        .error_count    (error_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: count of owed responses, FIFO as a queue of {id, resp}, error tally.
    int                 m_out;
    logic [IW+BW-1:0]   m_q[$];
    int                 m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [IW+BW-1:0] h;
        check_eq("issue_ready", 32'(issue_ready), 32'((m_out + m_q.size()) < DEPTH));
        check_eq("outstanding", 32'(outstanding), 32'(m_out));
        check_eq("bready", 32'(bready), 32'(m_out != 0));
        check_eq("busy", 32'(control_busy), 32'((m_out != 0) || (m_q.size() != 0)));
        check_eq("sys_valid", 32'(system_valid), 32'(m_q.size() != 0));
        check_eq("err_count", 32'(error_count), 32'(m_err));
        if (m_q.size() != 0) begin
            h = m_q[0];
            check_eq("sys_id", 32'(system_id), 32'(h[IW+BW-1:BW]));
            check_eq("sys_resp", 32'(system_response), 32'(h[BW-1:0]));
            check_eq("sys_err", 32'(system_error), 32'(h[1]));
        end
    endtask

    task automatic model_clear();
        m_out = 0;
        m_q.delete();
        m_err = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, 32'(issue_ready), 32'd1);
        check_eq({tag, "_out"}, 32'(outstanding), 32'd0);
        check_eq({tag, "_bready"}, 32'(bready), 32'd0);
        check_eq({tag, "_valid"}, 32'(system_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(control_busy), 32'd0);
        check_eq({tag, "_errc"}, 32'(error_count), 32'd0);
        check_eq({tag, "_id"}, 32'(system_id), 32'd0);
        check_eq({tag, "_resp"}, 32'(system_response), 32'd0);
        check_eq({tag, "_serr"}, 32'(system_error), 32'd0);
    endtask

    // Apply one cycle of inputs, advance the model by the spec rules, then compare.
    task automatic step(input logic iss, input logic bv, input logic [BW-1:0] br,
                        input logic [IW-1:0] bi, input logic sr, input logic ec);
        bit can_issue, accept, pop;
        control_issue = iss;
        bvalid        = bv;
        bresp         = br;
        bid           = bi;
        system_ready  = sr;
        error_clear   = ec;
        can_issue = iss && ((m_out + m_q.size()) < DEPTH);
        accept    = bv && (m_out != 0);
        pop       = sr && (m_q.size() != 0);
        @(posedge clock);
        #1;
        if (pop) void'(m_q.pop_front());
        if (accept) m_q.push_back({bi, br});
        m_out = m_out + int'(can_issue) - int'(accept);
`ifdef MASTER_AXI_WRITE_RESPONSE_ERROR_COUNT_EN
        if (ec) m_err = 0;
        else if (accept && br[1] && m_err < (1 << CW) - 1) m_err++;
`endif
        check_model();
    endtask

    task automatic do_reset(input string tag);
        control_issue = 0;
        bvalid        = 0;
        bresp         = '0;
        bid           = '0;
        system_ready  = 0;
        error_clear   = 0;
        reset         = 1;
        #2;
        model_clear();
        check_reset_values(tag);
        @(posedge clock);
        #1;
        reset = 0;
        check_model();
    endtask

    initial begin
        reset = 0;
        model_clear();
        do_reset("rst");

        // Idle: unsolicited response never accepted
        step(0, 1, 2'd0, 4'd3, 0, 0);
        step(0, 1, 2'd0, 4'd3, 1, 0);
        check_eq("idle_valid", 32'(system_valid), 32'd0);

        // Single transaction
        step(1, 0, 2'd0, 4'd0, 0, 0);
        check_eq("single_bready", 32'(bready), 32'd1);
        step(0, 0, 2'd0, 4'd0, 0, 0);
        step(0, 1, 2'd0, 4'd5, 0, 0);
        check_eq("single_id", 32'(system_id), 32'd5);
        check_eq("single_err", 32'(system_error), 32'd0);
        step(0, 0, 2'd0, 4'd0, 1, 0);
        check_eq("single_busy", 32'(control_busy), 32'd0);

        // Fill: fifth issue ignored, buffered responses block further credit
        for (int i = 0; i < 5; i++) step(1, 0, 2'd0, 4'd0, 0, 0);
        check_eq("fill_out", 32'(outstanding), 32'd4);
        check_eq("fill_ready", 32'(issue_ready), 32'd0);
        for (int i = 1; i <= 4; i++) step(1, 1, 2'd0, 4'(i), 0, 0);
        check_eq("fill_bready", 32'(bready), 32'd0);
        check_eq("fill_ready2", 32'(issue_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check_eq("fill_order", 32'(system_id), 32'(i));
            step(0, 0, 2'd0, 4'd0, 1, 0);
        end

        // Simultaneous issue/accept and push/pop across pointer wrap
        step(1, 0, 2'd0, 4'd0, 0, 0);
        step(1, 1, 2'd1, 4'd0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 1, 2'd0, 4'(i), 1, 0);
            check_eq("wrap_out", 32'(outstanding), 32'd1);
            check_eq("wrap_head", 32'(system_id), 32'(i));
        end
        step(0, 1, 2'd0, 4'd0, 1, 0);
        step(0, 0, 2'd0, 4'd0, 1, 0);
        check_eq("wrap_idle", 32'(control_busy), 32'd0);

        // Errors: five error responses saturate, then clear beats a DECERR
        for (int i = 0; i < 4; i++) step(1, 0, 2'd0, 4'd0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 2'(2 + (i % 2)), 4'(i), 1, 0);
        step(1, 0, 2'd0, 4'd0, 1, 0);
        step(0, 1, 2'd2, 4'd9, 1, 0);
`ifdef MASTER_AXI_WRITE_RESPONSE_ERROR_COUNT_EN
        check_eq("err_sat", 32'(error_count), 32'd3);
`else
        check_eq("err_off", 32'(error_count), 32'd0);
`endif
        step(1, 0, 2'd0, 4'd0, 1, 0);
        step(0, 1, 2'd3, 4'd7, 1, 1);
        check_eq("err_clear", 32'(error_count), 32'd0);
        step(0, 0, 2'd0, 4'd0, 1, 0);

        // Reset mid-flight: 2 owed, 1 buffered
        for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 4'd0, 0, 0);
        step(0, 1, 2'd2, 4'd6, 0, 0);
        reset = 1;
        #1;
        model_clear();
        check_reset_values("mid");
        @(posedge clock);
        #1;
        reset = 0;
        step(0, 1, 2'd0, 4'd8, 0, 0);
        check_eq("late_bvalid", 32'(system_valid), 32'd0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step(1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 60),
                     2'($urandom), 4'($urandom), 1'($urandom_range(0, 99) < 45),
                     1'($urandom_range(0, 99) < 3));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
